// File: rtl/mem_latency_port.sv
// mem_latency_port: fixed-latency, tagged main-memory endpoint with a synthesizable backing store.
// Define MEM_LATE_READ_EN to read the store in the completion cycle instead of at acceptance.
module mem_latency_port #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        proc2mem_command,
    input  logic [ADDR_W-1:0] proc2mem_addr,
    input  logic [63:0]       proc2mem_data,
    output logic [3:0]        mem2proc_response,
    output logic [63:0]       mem2proc_data,
    output logic [3:0]        mem2proc_tag
);

    localparam int unsigned    IDX_W   = ADDR_W - 3;
    localparam int unsigned    MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W:0] DEPTH_W = (IDX_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        CmdNone  = 2'd0,
        CmdLoad  = 2'd1,
        CmdStore = 2'd2,
        CmdRsvd  = 2'd3
    } cmd_e;

    logic [63:0]       mem [DEPTH];

    logic [IDX_W-1:0]  req_idx;
    logic [MEM_AW-1:0] req_addr;
    logic              req_in_range;
    logic              is_load;
    logic              is_store;
    logic              load_accept;
    logic              accept;
    logic              unused_addr_bits;

    logic [3:0]        ptr;
    logic [3:0]        ptr_next;
    logic [15:0]       in_use;

    logic              pipe_valid [LATENCY];
    logic [3:0]        pipe_tag   [LATENCY];
    logic              leave;
    logic [3:0]        leave_tag;
    logic [3:0]        out_tag;

    assign req_idx          = proc2mem_addr[ADDR_W-1:3];
    assign req_addr         = req_idx[MEM_AW-1:0];
    assign req_in_range     = {1'b0, req_idx} < DEPTH_W;
    assign unused_addr_bits = ^proc2mem_addr[2:0];

    // Reserved command decodes to neither, so it behaves as NONE.
    assign is_load     = reset && (proc2mem_command == CmdLoad);
    assign is_store    = reset && (proc2mem_command == CmdStore);
    assign load_accept = is_load && !in_use[ptr];
    assign accept      = load_accept || is_store;

    assign ptr_next          = (ptr == 4'd15) ? 4'd1 : ptr + 4'd1;
    assign mem2proc_response = accept ? ptr : 4'd0;

    assign leave     = pipe_valid[LATENCY-1];
    assign leave_tag = pipe_tag[LATENCY-1];
    assign mem2proc_tag = out_tag;

    // Backing store survives reset; out-of-range stores are dropped.
    always_ff @(posedge clock) begin
        if (is_store && req_in_range) begin
            mem[req_addr] <= proc2mem_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr     <= 4'd1;
            in_use  <= 16'd0;
            out_tag <= 4'd0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
            end
        end else begin
            if (accept) begin
                ptr <= ptr_next;
            end
            // The leaving tag is in use, so it can never equal an accepted ptr.
            if (leave) begin
                in_use[leave_tag] <= 1'b0;
            end
            if (load_accept) begin
                in_use[ptr] <= 1'b1;
            end
            pipe_valid[0] <= load_accept;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
            out_tag <= leave ? leave_tag : 4'd0;
        end
    end

    always_ff @(posedge clock) begin
        pipe_tag[0] <= ptr;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_tag[i] <= pipe_tag[i-1];
        end
    end

`ifdef MEM_LATE_READ_EN

    logic [MEM_AW-1:0] pipe_addr [LATENCY];
    logic              pipe_inr  [LATENCY];
    logic [MEM_AW-1:0] out_addr;
    logic              out_inr;

    always_ff @(posedge clock) begin
        pipe_addr[0] <= req_addr;
        pipe_inr[0]  <= req_in_range;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_addr[i] <= pipe_addr[i-1];
            pipe_inr[i]  <= pipe_inr[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            out_addr <= '0;
            out_inr  <= 1'b0;
        end else begin
            out_addr <= pipe_addr[LATENCY-1];
            out_inr  <= leave && pipe_inr[LATENCY-1];
        end
    end

    // Combinational read in the completion cycle: a store in this same cycle lands after it.
    assign mem2proc_data = ((out_tag != 4'd0) && out_inr) ? mem[out_addr] : 64'd0;

`else

    logic [63:0] rd_data;
    logic [63:0] pipe_data [LATENCY];
    logic [63:0] out_data;

    assign rd_data = req_in_range ? mem[req_addr] : 64'd0;

    always_ff @(posedge clock) begin
        pipe_data[0] <= rd_data;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_data[i] <= pipe_data[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            out_data <= 64'd0;
        end else begin
            out_data <= leave ? pipe_data[LATENCY-1] : 64'd0;
        end
    end

    assign mem2proc_data = out_data;

`endif

endmodule
